// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter: shares one memory between instruction fetch and load/store.
// Data side has priority; a streak counter forces a fetch grant after STARVE_MAX contended data grants.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [XLEN-1:0]     if_rdata_o,
    output logic                if_err_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [XLEN-1:0]     dm_wdata_i,
    input  logic [XLEN/8-1:0]   dm_wstrb_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [XLEN-1:0]     dm_rdata_o,
    output logic                dm_err_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic [XLEN/8-1:0]   mem_wstrb_o,
    input  logic [XLEN-1:0]     mem_rdata_i,
    input  logic                mem_ready_i,
    output logic                busy_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       streak_q, streak_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                mem_ce_q, mem_ce_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [XLEN/8-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                if_err_q, if_err_d;
    logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
    logic                dm_rvalid_q, dm_rvalid_d;
    logic                dm_err_q, dm_err_d;
    logic [XLEN-1:0]     dm_rdata_q, dm_rdata_d;
    logic                force_if;
    logic                timeout_hit;
    logic                if_gnt, dm_gnt;

    always_comb begin
        force_if    = (streak_q == SW'(STARVE_MAX));
        timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));
        if_gnt      = rst_i && (state_q == IDLE) && if_req_i && (!dm_req_i || force_if);
        dm_gnt      = rst_i && (state_q == IDLE) && dm_req_i && !(if_req_i && force_if);

        state_d     = state_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rvalid_d = 1'b0;
        dm_err_d    = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_gnt) begin
                    state_d     = BUSY_IF;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    timer_d     = '0;
                    streak_d    = '0;
                end else if (dm_gnt) begin
                    state_d     = BUSY_DM;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    mem_wstrb_d = dm_we_i ? dm_wstrb_i : '0;
                    timer_d     = '0;
                    // Only a grant that made fetch wait counts toward starvation.
                    if (if_req_i)
                        streak_d = force_if ? streak_q : streak_q + SW'(1);
                    else
                        streak_d = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready_i || timeout_hit) begin
                    state_d  = IDLE;
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_rvalid_d = 1'b1;
                        if_err_d    = !mem_ready_i;
                        if_rdata_d  = mem_ready_i ? mem_rdata_i : '0;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_err_d    = !mem_ready_i;
                        dm_rdata_d  = (mem_ready_i && !mem_we_q) ? mem_rdata_i : '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            timer_q     <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_err_q    <= dm_err_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_gnt_o    = if_gnt;
    assign dm_gnt_o    = dm_gnt;
    assign if_rvalid_o = if_rvalid_q;
    assign if_err_o    = if_err_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rvalid_o = dm_rvalid_q;
    assign dm_err_o    = dm_err_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, store, starvation order, timeout and mid-access reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifGnt, ifRvalid, ifErr;
    logic [31:0] ifRdata;
    logic        dmReq, dmWe;
    logic [31:0] dmAddr, dmWdata;
    logic [3:0]  dmWstrb;
    logic        dmGnt, dmRvalid, dmErr;
    logic [31:0] dmRdata;
    logic        memCe, memWe;
    logic [31:0] memAddr, memWdata;
    logic [3:0]  memWstrb;
    logic [31:0] memRdata;
    logic        memReady;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt),
        .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata), .if_err_o(ifErr),
        .dm_req_i(dmReq), .dm_we_i(dmWe), .dm_addr_i(dmAddr), .dm_wdata_i(dmWdata),
        .dm_wstrb_i(dmWstrb), .dm_gnt_o(dmGnt), .dm_rvalid_o(dmRvalid),
        .dm_rdata_o(dmRdata), .dm_err_o(dmErr),
        .mem_ce_o(memCe), .mem_we_o(memWe), .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata), .mem_wstrb_o(memWstrb),
        .mem_rdata_i(memRdata), .mem_ready_i(memReady), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic r, input logic iq, input logic dq, input logic we,
                                 input logic mr, input logic [31:0] md);
        rst      = r;
        ifReq    = iq;
        dmReq    = dq;
        dmWe     = we;
        memReady = mr;
        memRdata = md;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ifAddr  = 32'h10;
        dmAddr  = 32'h100;
        dmWdata = 32'h0;
        dmWstrb = 4'h0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Two reset edges with both requests pending: everything quiet.
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_ce", memCe, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_dmgnt", dmGnt, 0);
            checkOutput("rst_ifgnt", ifGnt, 0);
            checkOutput("rst_rvalid", {dmRvalid, ifRvalid}, 0);
            checkOutput("rst_addr", memAddr, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rel_dmgnt", dmGnt, 1);
        checkOutput("rel_ifgnt", ifGnt, 0);

        tick();
        checkOutput("ld_ce", memCe, 1);
        checkOutput("ld_addr", memAddr, 32'h100);
        checkOutput("ld_busy", busy, 1);
        checkOutput("ld_nognt", dmGnt, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        tick();
        checkOutput("ld_rvalid", dmRvalid, 1);
        checkOutput("ld_rdata", dmRdata, 32'hCAFEF00D);
        checkOutput("ld_err", dmErr, 0);
        checkOutput("ld_ce_off", memCe, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("ld_pulse", dmRvalid, 0);
        checkOutput("ld_hold", dmRdata, 32'hCAFEF00D);

        // Single fetch, memory answers on the second busy cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("if_gnt", ifGnt, 1);
        tick();
        checkOutput("if_addr", memAddr, 32'h10);
        checkOutput("if_we", memWe, 0);
        checkOutput("if_wstrb", memWstrb, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("if_wait", ifRvalid, 0);
        checkOutput("if_wait_ce", memCe, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        checkOutput("if_rvalid", ifRvalid, 1);
        checkOutput("if_rdata", ifRdata, 32'hDEADBEEF);
        checkOutput("if_err", ifErr, 0);
        checkOutput("if_busy_off", busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("if_pulse", ifRvalid, 0);

        // Store: read data returned must be forced to zero.
        dmAddr  = 32'h200;
        dmWdata = 32'h12345678;
        dmWstrb = 4'hF;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("st_gnt", dmGnt, 1);
        tick();
        checkOutput("st_we", memWe, 1);
        checkOutput("st_wstrb", memWstrb, 4'hF);
        checkOutput("st_wdata", memWdata, 32'h12345678);
        checkOutput("st_addr", memAddr, 32'h200);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        tick();
        checkOutput("st_rvalid", dmRvalid, 1);
        checkOutput("st_rdata", dmRdata, 0);
        checkOutput("st_we_off", memWe, 0);

        // Both requesters saturate the port: DM x4, IF, DM x4, IF.
        dmAddr = 32'h300;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5);
        for (int g = 0; g < 10; g++) begin
            #1;
            checkOutput($sformatf("starve_if%0d", g), ifGnt, (g == 4 || g == 9) ? 1 : 0);
            checkOutput($sformatf("starve_dm%0d", g), dmGnt, (g == 4 || g == 9) ? 0 : 1);
            tick();
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Timeout abort after 16 cycles of mem_ce with no ready.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("to_before", dmRvalid, 0);
        checkOutput("to_busy", busy, 1);
        tick();
        checkOutput("to_rvalid", dmRvalid, 1);
        checkOutput("to_err", dmErr, 1);
        checkOutput("to_rdata", dmRdata, 0);
        checkOutput("to_ce", memCe, 0);
        tick();
        checkOutput("to_pulse", {dmRvalid, dmErr}, 0);

        // Ready on the final allowed cycle wins over the timeout.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("edge_before", dmRvalid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA);
        tick();
        checkOutput("edge_rvalid", dmRvalid, 1);
        checkOutput("edge_err", dmErr, 0);
        checkOutput("edge_rdata", dmRdata, 32'h55AA55AA);

        // Build streak to the limit, then reset during the fourth data access.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("pre_dm%0d", g), dmGnt, 1);
            tick();
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("pre_dm3", dmGnt, 1);
        tick();
        checkOutput("mid_busy", busy, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("mid_ce", memCe, 0);
        checkOutput("mid_busy_off", busy, 0);
        checkOutput("mid_rvalid", dmRvalid, 0);
        checkOutput("mid_gnt", {ifGnt, dmGnt}, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("post_dmgnt", dmGnt, 1);
        checkOutput("post_ifgnt", ifGnt, 0);
        tick();
        checkOutput("post_rvalid", dmRvalid, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
